flr_resp_ctrl: RTL and testbench
================================

FLR_RESP_CTRL -- requirements
Module: flr_resp_ctrl

Interface
REQ-001 Parameter VF_FIFO_DEPTH, default 4: VF FLR request queue depth, power of 2, >=2.
REQ-002 Parameter RST_CYCLES, default 16: function-reset assertion length in cycles, >=1.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: quiesce wait limit; used only under FLR_TIMEOUT_EN.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_flr_pf_active  in  8  per-PF FLR request level from the PCIe side.
REQ-007 i_flr_rcvd_vf  in  1  one-cycle VF FLR request strobe.
REQ-008 i_flr_rcvd_pf_num / i_flr_rcvd_vf_num  in  3 / 11  parent PF and VF of the strobed request.
REQ-009 o_flr_pf_done  out  8  per-PF FLR done level.
REQ-010 o_flr_completed_vf  out  1  one-cycle VF FLR completion strobe.
REQ-011 o_flr_completed_pf_num / o_flr_completed_vf_num  out  3 / 11  function identity of the completion.
REQ-012 o_func_rst  out  1  reset to the function in service.
REQ-013 o_func_rst_vf_active / o_func_rst_pf_num / o_func_rst_vf_num  out  1 / 3 / 11  identity of the function in service.
REQ-014 i_func_quiesced  in  1  function in service is idle.
REQ-015 o_vf_overflow  out  1  sticky: a VF request was dropped.
REQ-016 o_flr_timeout  out  1  sticky: a quiesce wait timed out.

Function
REQ-017 All outputs registered; no combinational input-to-output path.
REQ-018 FSM states: IDLE, RESET, WAIT_Q, DONE.
REQ-019 PF i is pending when i_flr_pf_active[i]=1, o_flr_pf_done[i]=0 and PF i is not in service.
REQ-020 IDLE arbitration: the lowest-index pending PF wins; otherwise the VF FIFO head is popped; otherwise stay in IDLE.
REQ-021 IDLE to RESET: latch identity, drive o_func_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_Q with o_func_rst=0.
REQ-022 WAIT_Q: go to DONE in the cycle after i_func_quiesced=1 is sampled; minimum one cycle in WAIT_Q.
REQ-023 DONE, one cycle, then IDLE:
  - PF request: set o_flr_pf_done[pf].
  - VF request: pulse o_flr_completed_vf for one cycle with the latched numbers.
REQ-024 o_flr_pf_done[i] clears the cycle after i_flr_pf_active[i]=0 is sampled.
REQ-025 PF in service drops i_flr_pf_active mid-sequence: the sequence still completes; o_flr_pf_done is not set.
REQ-026 Latency with i_func_quiesced held high, idle and empty queue:
  - PF: o_flr_pf_done rises RST_CYCLES+3 cycles after i_flr_pf_active rises.
  - VF: o_flr_completed_vf pulses RST_CYCLES+4 cycles after the strobe.
REQ-027 VF FIFO is in-order with no merging of duplicate requests.
REQ-028 Push while full without a same-cycle pop: the request is dropped and o_vf_overflow is set.
REQ-029 Push and pop in the same cycle while full: the push is accepted.
REQ-030 VF requests arriving during a PF sequence are queued and serviced after the PF completes.

Reset
REQ-031 rst=1 returns the FSM to IDLE, empties the FIFO and clears the counters.
REQ-032 rst=1 drives every output to 0, including the sticky flags, in the next cycle, even mid-sequence.
REQ-033 An aborted sequence produces no completion.

Configuration
REQ-034 Macro FLR_TIMEOUT_EN defined:
  - WAIT_Q exits to DONE after TIMEOUT_CYCLES cycles without i_func_quiesced.
  - The completion is still issued.
  - o_flr_timeout is set (sticky).
REQ-035 Macro FLR_TIMEOUT_EN undefined: WAIT_Q waits indefinitely and o_flr_timeout is tied 0.

Verification
REQ-036 PF3 FLR: i_flr_pf_active[3]=1, quiesced=1 -> o_func_rst high 16 cycles, pf_num=3; o_flr_pf_done[3] at +19; cleared 1 cycle after active drops.
REQ-037 VF strobe PF1/VF 0x2A5, quiesced=1 -> one completion pulse at +20 with pf=1, vf=0x2A5.
REQ-038 Strobe 6 VFs back-to-back while PF0 is in service (depth 4) -> o_vf_overflow=1; first 4 VFs complete in order; last 2 never complete.
REQ-039 PF5 and PF2 asserted in the same cycle -> PF2 serviced first, then PF5.
REQ-040 rst pulsed mid-RESET for a VF -> all outputs 0 next cycle; no completion strobe.
REQ-041 FLR_TIMEOUT_EN, TIMEOUT_CYCLES=64, quiesced held 0 -> completion after 64 cycles in WAIT_Q, o_flr_timeout=1; without the macro -> no completion, o_flr_timeout=0.

Source files
------------

// File: rtl/flr_resp_ctrl.sv
// flr_resp_ctrl: function-level-reset responder for PFs and VFs.
// Physical-function (PF) requests arrive as levels.
// Virtual-function (VF) requests arrive as strobes and are queued in a small FIFO.
// Functions are serviced one at a time: reset pulse, then quiesce wait, then completion.
// Optional feature: define FLR_TIMEOUT_EN to bound the quiesce wait with TIMEOUT_CYCLES.
`timescale 1ns/1ps
module flr_resp_ctrl #(
  parameter int VF_FIFO_DEPTH  = 4,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_flr_pf_active,
  input  logic        i_flr_rcvd_vf,
  input  logic [2:0]  i_flr_rcvd_pf_num,
  input  logic [10:0] i_flr_rcvd_vf_num,
  output logic [7:0]  o_flr_pf_done,
  output logic        o_flr_completed_vf,
  output logic [2:0]  o_flr_completed_pf_num,
  output logic [10:0] o_flr_completed_vf_num,
  output logic        o_func_rst,
  output logic        o_func_rst_vf_active,
  output logic [2:0]  o_func_rst_pf_num,
  output logic [10:0] o_func_rst_vf_num,
  input  logic        i_func_quiesced,
  output logic        o_vf_overflow,
  output logic        o_flr_timeout
);

  localparam int PTR_W   = $clog2(VF_FIFO_DEPTH);
  localparam int CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RESET  = 2'd1;
  localparam logic [1:0] S_WAIT_Q = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             pf_dropped;

  logic [13:0]      fifo_mem [VF_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [13:0]      fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_push;
  logic             do_pop;

  logic [7:0]       pf_pending;
  logic             pf_any;
  logic [2:0]       pf_win;

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(VF_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  // Arbitration: the only PF that can be in service is absent while in IDLE,
  // so pending reduces to requested-and-not-yet-done. The lowest index wins.
  always_comb begin
    pf_pending = i_flr_pf_active & ~o_flr_pf_done;
    pf_any     = |pf_pending;
    pf_win     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pf_pending[i]) pf_win = 3'(i);
    end
  end

  // A VF is popped only when IDLE has no PF to serve. A push into a full queue
  // survives only if the head leaves in the same cycle.
  assign do_pop  = (state == S_IDLE) && !pf_any && !fifo_empty;
  assign do_push = i_flr_rcvd_vf && (!fifo_full || do_pop);

  // The queue storage needs no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= {i_flr_rcvd_pf_num, i_flr_rcvd_vf_num};
  end

  // Queue pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      o_vf_overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (i_flr_rcvd_vf && !do_push) o_vf_overflow <= 1'b1;
    end
  end

  // Service sequencer. The identity outputs double as the latched record of
  // the function in service. They are cleared when the sequence finishes.
`ifdef FLR_TIMEOUT_EN
  logic timeout_flag;
  assign o_flr_timeout = timeout_flag;
`else
  assign o_flr_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      cnt                    <= '0;
      pf_dropped             <= 1'b0;
      o_flr_pf_done          <= '0;
      o_flr_completed_vf     <= 1'b0;
      o_flr_completed_pf_num <= '0;
      o_flr_completed_vf_num <= '0;
      o_func_rst             <= 1'b0;
      o_func_rst_vf_active   <= 1'b0;
      o_func_rst_pf_num      <= '0;
      o_func_rst_vf_num      <= '0;
`ifdef FLR_TIMEOUT_EN
      timeout_flag           <= 1'b0;
`endif
    end else begin
      o_flr_completed_vf     <= 1'b0;
      o_flr_completed_pf_num <= '0;
      o_flr_completed_vf_num <= '0;
      o_flr_pf_done          <= o_flr_pf_done & i_flr_pf_active;
      case (state)
        S_IDLE: begin
          if (pf_any) begin
            state                <= S_RESET;
            cnt                  <= '0;
            pf_dropped           <= 1'b0;
            o_func_rst           <= 1'b1;
            o_func_rst_vf_active <= 1'b0;
            o_func_rst_pf_num    <= pf_win;
            o_func_rst_vf_num    <= '0;
          end else if (!fifo_empty) begin
            state                <= S_RESET;
            cnt                  <= '0;
            pf_dropped           <= 1'b0;
            o_func_rst           <= 1'b1;
            o_func_rst_vf_active <= 1'b1;
            o_func_rst_pf_num    <= fifo_head[13:11];
            o_func_rst_vf_num    <= fifo_head[10:0];
          end
        end
        S_RESET: begin
          if (!o_func_rst_vf_active && !i_flr_pf_active[o_func_rst_pf_num]) pf_dropped <= 1'b1;
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state      <= S_WAIT_Q;
            cnt        <= '0;
            o_func_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_Q: begin
          if (!o_func_rst_vf_active && !i_flr_pf_active[o_func_rst_pf_num]) pf_dropped <= 1'b1;
          if (i_func_quiesced) begin
            state <= S_DONE;
          end
`ifdef FLR_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state        <= S_DONE;
            timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          if (o_func_rst_vf_active) begin
            o_flr_completed_vf     <= 1'b1;
            o_flr_completed_pf_num <= o_func_rst_pf_num;
            o_flr_completed_vf_num <= o_func_rst_vf_num;
          end else if (i_flr_pf_active[o_func_rst_pf_num] && !pf_dropped) begin
            o_flr_pf_done[o_func_rst_pf_num] <= 1'b1;
          end
          o_func_rst_vf_active <= 1'b0;
          o_func_rst_pf_num    <= '0;
          o_func_rst_vf_num    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flr_resp_ctrl.sv
// tb_flr_resp_ctrl: directed self-checking bench for flr_resp_ctrl.
// The design is built with depth 4, 16 reset cycles and a 64-cycle timeout.
// Expectations follow FLR_TIMEOUT_EN as compiled.
`timescale 1ns/1ps
module tb_flr_resp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_flr_pf_active;
  logic        i_flr_rcvd_vf;
  logic [2:0]  i_flr_rcvd_pf_num;
  logic [10:0] i_flr_rcvd_vf_num;
  logic [7:0]  o_flr_pf_done;
  logic        o_flr_completed_vf;
  logic [2:0]  o_flr_completed_pf_num;
  logic [10:0] o_flr_completed_vf_num;
  logic        o_func_rst;
  logic        o_func_rst_vf_active;
  logic [2:0]  o_func_rst_pf_num;
  logic [10:0] o_func_rst_vf_num;
  logic        i_func_quiesced;
  logic        o_vf_overflow;
  logic        o_flr_timeout;

  int nCompared   = 0;
  int nMismatched = 0;

  flr_resp_ctrl #(
    .VF_FIFO_DEPTH (4),
    .RST_CYCLES    (16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_flr_pf_active       (i_flr_pf_active),
    .i_flr_rcvd_vf         (i_flr_rcvd_vf),
    .i_flr_rcvd_pf_num     (i_flr_rcvd_pf_num),
    .i_flr_rcvd_vf_num     (i_flr_rcvd_vf_num),
    .o_flr_pf_done         (o_flr_pf_done),
    .o_flr_completed_vf    (o_flr_completed_vf),
    .o_flr_completed_pf_num(o_flr_completed_pf_num),
    .o_flr_completed_vf_num(o_flr_completed_vf_num),
    .o_func_rst            (o_func_rst),
    .o_func_rst_vf_active  (o_func_rst_vf_active),
    .o_func_rst_pf_num     (o_func_rst_pf_num),
    .o_func_rst_vf_num     (o_func_rst_vf_num),
    .i_func_quiesced       (i_func_quiesced),
    .o_vf_overflow         (o_vf_overflow),
    .o_flr_timeout         (o_flr_timeout)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Advance one cycle and settle 1 ns past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every output must be at zero.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".pf_done"},   32'(o_flr_pf_done), 32'h0);
    checkOutput({tag, ".cmpl"},      {13'h0, o_flr_completed_vf, o_flr_completed_pf_num, o_flr_completed_vf_num}, 32'h0);
    checkOutput({tag, ".func_rst"},  {13'h0, o_func_rst, o_func_rst_vf_active, o_func_rst_pf_num, o_func_rst_vf_num}, 32'h0);
    checkOutput({tag, ".sticky"},    {30'h0, o_vf_overflow, o_flr_timeout}, 32'h0);
  endtask

  // Directed sequence.
  initial begin
    int rstHigh;
    int doneAt;
    int pulses;
    int pulseAt;
    logic [2:0]  gotPf;
    logic [10:0] gotVf;
    logic [10:0] vfOrder[$];
    logic [2:0]  svcOrder[$];
    logic        prevRst;

    rst = 1'b1;
    i_flr_pf_active = '0;
    i_flr_rcvd_vf = 1'b0;
    i_flr_rcvd_pf_num = '0;
    i_flr_rcvd_vf_num = '0;
    i_func_quiesced = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkAllZero("reset");

    // PF3: a 16-cycle reset with pf_num 3, done at +19, cleared one cycle after the drop.
    i_flr_pf_active = 8'h08;
    rstHigh = 0; doneAt = 0;
    for (int k = 1; k <= 25; k++) begin
      applyStimulus();
      if (k == 1) checkOutput("pf3.pf_num", 32'(o_func_rst_pf_num), 32'd3);
      if (o_func_rst) rstHigh++;
      if (o_flr_pf_done[3] && doneAt == 0) doneAt = k;
    end
    checkOutput("pf3.rst_len", 32'(rstHigh), 32'd16);
    checkOutput("pf3.done_at", 32'(doneAt), 32'd19);
    checkOutput("pf3.done_vec", 32'(o_flr_pf_done), 32'h08);
    i_flr_pf_active = 8'h00;
    applyStimulus();
    checkOutput("pf3.done_clear", 32'(o_flr_pf_done), 32'h00);

    // VF strobe for PF1/VF 0x2A5: exactly one completion, at +20.
    i_flr_rcvd_vf = 1'b1; i_flr_rcvd_pf_num = 3'd1; i_flr_rcvd_vf_num = 11'h2A5;
    pulses = 0; pulseAt = 0; gotPf = '0; gotVf = '0;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus();
      i_flr_rcvd_vf = 1'b0;
      if (k == 2) checkOutput("vf.rst_id", {o_func_rst_vf_active, o_func_rst_pf_num, o_func_rst_vf_num}, {17'h0, 1'b1, 3'd1, 11'h2A5});
      if (o_flr_completed_vf) begin
        pulses++; pulseAt = k; gotPf = o_flr_completed_pf_num; gotVf = o_flr_completed_vf_num;
      end
    end
    checkOutput("vf.pulses", 32'(pulses), 32'd1);
    checkOutput("vf.pulse_at", 32'(pulseAt), 32'd20);
    checkOutput("vf.pf_num", 32'(gotPf), 32'd1);
    checkOutput("vf.vf_num", 32'(gotVf), 32'h2A5);

    // Six VFs strobed during a PF0 sequence: four are kept in order and two are dropped.
    i_flr_pf_active = 8'h01;
    applyStimulus();
    for (int j = 0; j < 6; j++) begin
      i_flr_rcvd_vf = 1'b1; i_flr_rcvd_pf_num = 3'd2; i_flr_rcvd_vf_num = 11'(16 + j);
      applyStimulus();
    end
    i_flr_rcvd_vf = 1'b0;
    checkOutput("ovf.flag", 32'(o_vf_overflow), 32'd1);
    for (int k = 0; k < 200; k++) begin
      applyStimulus();
      if (o_flr_completed_vf) vfOrder.push_back(o_flr_completed_vf_num);
    end
    checkOutput("ovf.pf0_done", 32'(o_flr_pf_done), 32'h01);
    checkOutput("ovf.count", 32'(vfOrder.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      checkOutput("ovf.order", (j < vfOrder.size()) ? 32'(vfOrder[j]) : 32'hDEAD, 32'(16 + j));
    end
    i_flr_pf_active = 8'h00;
    applyStimulus();

    // PF5 and PF2 raised together: PF2 is serviced first, then PF5.
    i_flr_pf_active = 8'h24;
    prevRst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus();
      if (o_func_rst && !prevRst) svcOrder.push_back(o_func_rst_pf_num);
      prevRst = o_func_rst;
    end
    checkOutput("arb.count", 32'(svcOrder.size()), 32'd2);
    checkOutput("arb.first", (svcOrder.size() > 0) ? 32'(svcOrder[0]) : 32'hDEAD, 32'd2);
    checkOutput("arb.second", (svcOrder.size() > 1) ? 32'(svcOrder[1]) : 32'hDEAD, 32'd5);
    checkOutput("arb.done_vec", 32'(o_flr_pf_done), 32'h24);
    i_flr_pf_active = 8'h00;
    applyStimulus();
    checkOutput("arb.done_clear", 32'(o_flr_pf_done), 32'h00);

    // PF1 dropped mid-sequence: the reset still runs its full length and no done is raised.
    i_flr_pf_active = 8'h02;
    rstHigh = 0; doneAt = 0;
    for (int k = 1; k <= 35; k++) begin
      applyStimulus();
      if (k == 5) i_flr_pf_active = 8'h00;
      if (o_func_rst) rstHigh++;
      if (o_flr_pf_done != 8'h00) doneAt = k;
    end
    checkOutput("drop.rst_len", 32'(rstHigh), 32'd16);
    checkOutput("drop.no_done", 32'(doneAt), 32'd0);

    // rst pulsed mid-RESET for a VF: all outputs clear next cycle and no completion follows.
    i_flr_rcvd_vf = 1'b1; i_flr_rcvd_pf_num = 3'd4; i_flr_rcvd_vf_num = 11'h7FF;
    applyStimulus();
    i_flr_rcvd_vf = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("abort.in_rst", {o_func_rst, o_func_rst_vf_active}, 32'h3);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkAllZero("abort");
    pulses = 0; rstHigh = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus();
      if (o_flr_completed_vf) pulses++;
      if (o_func_rst) rstHigh++;
    end
    checkOutput("abort.no_cmpl", 32'(pulses), 32'd0);
    checkOutput("abort.idle", 32'(rstHigh), 32'd0);

    // PF7 with quiesce held low: times out at +82 when enabled, otherwise waits indefinitely.
    i_func_quiesced = 1'b0;
    i_flr_pf_active = 8'h80;
    doneAt = 0;
    for (int k = 1; k <= 150; k++) begin
      applyStimulus();
      if (o_flr_pf_done[7] && doneAt == 0) doneAt = k;
    end
`ifdef FLR_TIMEOUT_EN
    checkOutput("tmo.done_at", 32'(doneAt), 32'd82);
    checkOutput("tmo.flag", 32'(o_flr_timeout), 32'd1);
`else
    checkOutput("tmo.no_done", 32'(doneAt), 32'd0);
    checkOutput("tmo.flag", 32'(o_flr_timeout), 32'd0);
    i_func_quiesced = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("tmo.late_done", 32'(o_flr_pf_done), 32'h80);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
